// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the CPU front-end blocks.
//   ADDR_W           - PC / instruction-memory address width
//   INSTR_W          - instruction word width
//   CNT_W            - fetch counter width
//   DEFAULT_RESET_PC - PC value loaded on reset
//   fetch_state_t    - fetch-stage control state (IDLE, RUN, HALT)
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 16;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_pipe_reg.sv
// if_pipe_reg: valid/ready output register between fetch and decode.
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   load        - capture load_instr/load_pc and mark the register valid
//   hold        - decode is stalling a valid word; keep everything as is
//   clear       - the held word left for decode and nothing replaces it
//   flush       - discard the held word (branch redirect), overrides all
//   load_instr  - instruction word to capture
//   load_pc     - address of that word
//   valid       - register holds an instruction for decode
//   instr, pc   - held instruction and its address
module if_pipe_reg #(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               hold,
  input  logic               clear,
  input  logic               flush,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  import cpu_pkg::*;

  // A flush only drops the valid bit; the stale word stays in place but is
  // never observed by decode because valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (!hold) begin
      if (load) begin
        valid <= 1'b1;
        instr <= load_instr;
        pc    <= load_pc;
      end else if (clear) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage.
// Owns the program counter, presents it combinationally to instruction
// memory, and captures the returned word into a valid/ready register that
// feeds decode. Supports start/halt control, branch redirect with flush,
// decode back-pressure and a count of instructions handed to decode.
// Ports:
//   clk, rst_n           - rising-edge clock, asynchronous active-low reset
//   start                - pulse: IDLE/HALT -> RUN
//   halt_req             - pulse: RUN -> HALT
//   redirect_valid/_pc   - taken branch/jump and its target
//   imem_addr/imem_data  - combinational instruction memory interface
//   if_valid/if_ready    - handshake towards decode
//   if_instr/if_pc       - fetched word and its address
//   halted               - high whenever the stage is not in RUN
//   fetch_count          - instructions accepted by decode (wraps)
// Optional build macro FETCH_WRAP_TRAP_EN: a fetch at the last address
// halts the core at that address instead of wrapping to zero; only a
// redirect followed by start (or reset) resumes execution.
module if_fetch #(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::DEFAULT_RESET_PC,
  parameter int                CNT_W    = cpu_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               halt_req,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  import cpu_pkg::*;

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              fire;
  logic              transfer;
  logic              stall;
  logic              trap_hit;
  logic              trapped;

  assign imem_addr = pc;
  assign transfer  = if_valid && if_ready;
  assign stall     = if_valid && !if_ready;

`ifdef FETCH_WRAP_TRAP_EN
  // A trap is a normal fetch at the top address; the word is still issued.
  assign trap_hit = fire && (pc == {ADDR_W{1'b1}});

  // Remembers that we stopped on a trap so that a bare start cannot
  // re-fetch the top address; a redirect re-arms start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trapped <= 1'b0;
    end else if (redirect_valid) begin
      trapped <= 1'b0;
    end else if (trap_hit) begin
      trapped <= 1'b1;
    end
  end
`else
  assign trap_hit = 1'b0;
  assign trapped  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Halt beats start in RUN; halt is ignored outside RUN. Redirects never
  // change state, so IDLE is only left through start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (halt_req || trap_hit) state_nxt = HALT;
      HALT:    if (start && !trapped) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch only in RUN, never in a redirect or halt cycle, and only when the
  // output register is empty or being emptied this cycle.
  always_comb begin
    halted = 1'b1;
    fire   = 1'b0;
    if (state == RUN) begin
      halted = 1'b0;
      fire   = !redirect_valid && !halt_req && !stall;
    end
  end

  // Redirect has priority over sequential fetch in every state.
  always_comb begin
    pc_nxt = pc;
    if (redirect_valid) begin
      pc_nxt = redirect_pc;
    end else if (fire) begin
      pc_nxt = trap_hit ? pc : pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_nxt;
    end
  end

  // A word accepted in the same cycle as a redirect is discarded by the
  // flush, so it does not count as issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (transfer && !redirect_valid) begin
      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

  if_pipe_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (fire),
    .hold      (stall),
    .clear     (transfer),
    .flush     (redirect_valid),
    .load_instr(imem_data),
    .load_pc   (pc),
    .valid     (if_valid),
    .instr     (if_instr),
    .pc        (if_pc)
  );

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: self-checking bench for if_fetch.
// A table of per-cycle stimulus records with the outputs expected after the
// following rising edge is replayed through a scoreboard queue, followed by
// hand-written sequences for asynchronous reset and restart from reset.
// Honours FETCH_WRAP_TRAP_EN for the wrap-around expectations.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [256];

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        start;
    logic        halt_req;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        if_ready;
    logic        exp_valid;
    logic [7:0]  exp_pc;
    logic [7:0]  exp_addr;
    logic        exp_halted;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  if_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .halt_req      (halt_req),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  // Memory contents: the two words named in the test plan, then a
  // recognisable pattern carrying the address in the low byte.
  function automatic logic [31:0] wordAt(input logic [7:0] a);
    if (a == 8'h00) return 32'h0036E401;
    if (a == 8'h01) return 32'h0036E018;
    return {24'hA50000, a};
  endfunction

  function automatic vec_t mk(input logic st, input logic hr, input logic rv,
                              input logic [7:0] rpc, input logic rdy,
                              input logic ev, input logic [7:0] epc,
                              input logic [7:0] eaddr, input logic eh,
                              input logic [15:0] ecnt);
    vec_t v;
    v.start = st; v.halt_req = hr; v.redirect_valid = rv;
    v.redirect_pc = rpc; v.if_ready = rdy;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_addr = eaddr;
    v.exp_halted = eh; v.exp_cnt = ecnt;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  // Drive one cycle's inputs on the falling edge and queue what the DUT
  // should show after the next rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    start          = v.start;
    halt_req       = v.halt_req;
    redirect_valid = v.redirect_valid;
    redirect_pc    = v.redirect_pc;
    if_ready       = v.if_ready;
    sb.push_back(v);
  endtask

  task automatic checkOutput(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    checkVal({tag, " if_valid"},    {31'd0, if_valid},  {31'd0, e.exp_valid});
    checkVal({tag, " if_pc"},       {24'd0, if_pc},     {24'd0, e.exp_pc});
    checkVal({tag, " imem_addr"},   {24'd0, imem_addr}, {24'd0, e.exp_addr});
    checkVal({tag, " halted"},      {31'd0, halted},    {31'd0, e.exp_halted});
    checkVal({tag, " fetch_count"}, {16'd0, fetch_count}, {16'd0, e.exp_cnt});
    if (e.exp_valid) begin
      checkVal({tag, " if_instr"}, if_instr, wordAt(e.exp_pc));
    end
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, " if_valid"},    {31'd0, if_valid},    32'd0);
    checkVal({tag, " if_instr"},    if_instr,             32'd0);
    checkVal({tag, " if_pc"},       {24'd0, if_pc},       32'd0);
    checkVal({tag, " imem_addr"},   {24'd0, imem_addr},   32'd0);
    checkVal({tag, " halted"},      {31'd0, halted},      32'd1);
    checkVal({tag, " fetch_count"}, {16'd0, fetch_count}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;

    for (int i = 0; i < 256; i++) mem[i] = wordAt(8'(i));

    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 8'h00; if_ready = 1'b0;

    //                st hr rv rpc    rdy  val pc     addr   hlt cnt
    // straight-line fetch
    vecs.push_back(mk(1, 0, 0, 8'h00, 1,   0, 8'h00, 8'h00, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1,   1, 8'h00, 8'h01, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1,   1, 8'h01, 8'h02, 0, 16'd1));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1,   1, 8'h02, 8'h03, 0, 16'd2));
    // back-pressure at pc 2
    vecs.push_back(mk(0, 0, 0, 8'h00, 0,   1, 8'h02, 8'h03, 0, 16'd2));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0,   1, 8'h02, 8'h03, 0, 16'd2));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0,   1, 8'h02, 8'h03, 0, 16'd2));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1,   1, 8'h03, 8'h04, 0, 16'd3));
    // redirect during stall: flush, bubble, resume at 0C
    vecs.push_back(mk(0, 0, 1, 8'h0C, 0,   0, 8'h03, 8'h0C, 0, 16'd3));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0,   1, 8'h0C, 8'h0D, 0, 16'd3));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1,   1, 8'h0D, 8'h0E, 0, 16'd4));
    // halt at pc 5 with the held word accepted, restart resumes at 5
    vecs.push_back(mk(0, 0, 1, 8'h04, 0,   0, 8'h0D, 8'h04, 0, 16'd4));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1,   1, 8'h04, 8'h05, 0, 16'd4));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1,   0, 8'h04, 8'h05, 1, 16'd5));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1,   0, 8'h04, 8'h05, 1, 16'd5));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1,   0, 8'h04, 8'h05, 1, 16'd5));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1,   0, 8'h04, 8'h05, 0, 16'd5));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1,   1, 8'h05, 8'h06, 0, 16'd5));
    // halt while stalled: word stays until accepted
    vecs.push_back(mk(0, 1, 0, 8'h00, 0,   1, 8'h05, 8'h06, 1, 16'd5));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1,   0, 8'h05, 8'h06, 1, 16'd6));
    // halt ignored in HALT, halt beats start in RUN
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,   0, 8'h05, 8'h06, 0, 16'd6));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,   0, 8'h05, 8'h06, 1, 16'd6));
    // redirect in HALT loads pc only, then fetch across the top address
    vecs.push_back(mk(0, 0, 1, 8'hFF, 1,   0, 8'h05, 8'hFF, 1, 16'd6));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1,   0, 8'h05, 8'hFF, 0, 16'd6));
`ifdef FETCH_WRAP_TRAP_EN
    vecs.push_back(mk(0, 0, 0, 8'h00, 1,   1, 8'hFF, 8'hFF, 1, 16'd6));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1,   0, 8'hFF, 8'hFF, 1, 16'd7));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1,   0, 8'hFF, 8'hFF, 1, 16'd7));
`else
    vecs.push_back(mk(0, 0, 0, 8'h00, 1,   1, 8'hFF, 8'h00, 0, 16'd6));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1,   1, 8'h00, 8'h01, 0, 16'd7));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1,   1, 8'h01, 8'h02, 0, 16'd8));
`endif

    repeat (2) @(posedge clk);
    #1;
    checkReset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d", i));
    end

    // Get into RUN with a valid word in both builds, then reset between edges.
    @(negedge clk);
    start = 1'b0; halt_req = 1'b0; if_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 8'h20;
    @(negedge clk);
    redirect_valid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("prereset running", {31'd0, halted}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("async reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Restart from reset: first word must come from RESET_PC.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (if_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkVal("restart valid seen", {31'd0, seen}, 32'd1);
    checkVal("restart if_pc", {24'd0, if_pc}, 32'h00);
    checkVal("restart if_instr", if_instr, 32'h0036E401);
    checkVal("restart count", {16'd0, fetch_count}, 32'd0);
    @(posedge clk);
    #1;
    checkVal("restart2 if_pc", {24'd0, if_pc}, 32'h01);
    checkVal("restart2 if_instr", if_instr, 32'h0036E018);
    checkVal("restart2 count", {16'd0, fetch_count}, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage of the CPU.
- Owns the 8-bit program counter and drives the combinational instruction memory address.
- Captures the returned 32-bit word into a valid/ready output register feeding decode.
- Handles start/halt control, branch redirect with flush, decode back-pressure, and a fetch counter.

Parameters:
- ADDR_W, 8, PC / instruction-memory address width.
- INSTR_W, 32, instruction word width.
- RESET_PC, 8'h00, PC value loaded on reset.
- CNT_W, 16, fetch counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  pulse; IDLE/HALT -> RUN.
- halt_req  in  1  pulse; RUN -> HALT.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  ADDR_W  redirect target.
- imem_addr  out  ADDR_W  instruction memory address, equals pc register.
- imem_data  in  INSTR_W  instruction word, combinational from imem_addr.
- if_valid  out  1  if_instr/if_pc hold a valid instruction.
- if_ready  in  1  decode accepts this cycle.
- if_instr  out  INSTR_W  fetched instruction.
- if_pc  out  ADDR_W  address of if_instr.
- halted  out  1  high when state != RUN.
- fetch_count  out  CNT_W  number of instructions issued to decode.

Behaviour:
- Reset (async, rst_n=0) sets:
  - pc=RESET_PC, state=IDLE.
  - if_valid=0, if_instr=0, if_pc=0, fetch_count=0.
  - halted=1.
- Reset mid-operation discards the held instruction immediately.
- imem_addr = pc, combinational; no other path to imem.
- States:
  - IDLE -(start)-> RUN.
  - RUN -(halt_req)-> HALT.
  - HALT -(start)-> RUN.
  - IDLE never re-entered except by reset.
- Fetch condition: fire = (state==RUN) && !redirect_valid && (!if_valid || if_ready).
- On fire:
  - if_instr<=imem_data, if_pc<=pc, if_valid<=1, pc<=pc+1.
  - Latency: word at pc is visible on if_instr one cycle after pc is presented.
- Handshake:
  - Transfer occurs when if_valid && if_ready.
  - If if_valid && !if_ready, if_instr, if_pc and pc hold steady (stall).
  - If a transfer occurs without fire, if_valid<=0.
- fetch_count increments by 1 on each transfer (if_valid && if_ready); wraps modulo 2^CNT_W.
- Redirect (any state) has priority over fetch:
  - pc<=redirect_pc and if_valid<=0 (flush, even if decode is stalled).
  - A flushed word is not counted.
  - In RUN, one bubble cycle follows, then fetch resumes at redirect_pc.
  - In IDLE/HALT, only pc is loaded; the state is unchanged.
- halt_req in RUN:
  - No fire in the same cycle; state<=HALT.
  - Held if_valid word stays until accepted, then if_valid<=0.
- Simultaneous events:
  - halt_req together with start in RUN: halt wins.
  - start in RUN: ignored.
  - halt_req in IDLE/HALT: ignored.
  - redirect_valid and halt_req in the same RUN cycle: both apply (pc loaded, flush, go HALT).
- PC arithmetic is ADDR_W-bit unsigned; 8'hFF+1 wraps to 8'h00 unless FETCH_WRAP_TRAP_EN.

Optional Feature:
FETCH_WRAP_TRAP_EN
- Defined:
  - A fire at pc==8'hFF issues the word normally, then sets pc<=8'hFF (not 0) and state<=HALT.
  - The core stops instead of running off the end of memory.
  - Only start after a redirect, or reset, resumes execution.
- Undefined: plain modulo-256 wrap to 8'h00 and continued fetch.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W, INSTR_W constants.
  - fetch_state_t enum (IDLE, RUN, HALT).
  - RESET_PC default.
- One sub-module, if_pipe_reg:
  - Valid/ready output register holding if_instr/if_pc/if_valid.
  - Load, hold, clear and flush inputs.
- PC, FSM and counter stay in if_fetch.

Test Plan:
1. Straight-line fetch:
   - Stimulus: imem word0=32'h0036E401, word1=32'h0036E018, if_ready=1; reset, then start pulse.
   - Required: the cycle after fire, if_instr=32'h0036E401, if_pc=0; next cycle 32'h0036E018, if_pc=1; fetch_count increments each cycle.
2. Back-pressure:
   - Stimulus: if_ready=0 for 3 cycles while if_valid=1 at pc 2.
   - Required: if_instr/if_pc stable, imem_addr=3 held, fetch_count unchanged; release gives if_pc=3 next.
3. Redirect during stall:
   - Stimulus: if_valid=1, if_ready=0, redirect_valid=1, redirect_pc=8'h0C.
   - Required: if_valid=0 next cycle, then if_pc=8'h0C; flushed word not counted.
4. Halt/restart:
   - Stimulus: halt_req at pc 5 with held word accepted; later start pulse.
   - Required: halted=1, no further fetch; restart resumes at pc 5.
5. Async reset mid-run:
   - Stimulus: drop rst_n between clock edges.
   - Required: all outputs go to reset values immediately; pc=RESET_PC, halted=1.
6. Wrap:
   - Stimulus: redirect to 8'hFF in RUN.
   - Required without macro: if_pc=8'hFF then 8'h00. With FETCH_WRAP_TRAP_EN: if_pc=8'hFF, then halted=1, imem_addr=8'hFF.
